pushbutton_event_controller: RTL and testbench
==============================================

Name: pushbutton_event_controller

Overview:
- Memory-mapped controller for the KEY0-3 pushbuttons. It replaces raw pin sampling with three stages: synchronisation, per-button debounce, and press-edge capture.
- Holds a per-button press counter and a maskable interrupt.
- Sits between the board pushbutton pins and the processor's memory-mapped slave bus. Software polls it or takes the interrupt instead of reading raw levels.

Parameters:
- NUM_BUTTONS, 4, number of pushbutton inputs (1..8).
- DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles required to accept a level change (>=2); 1 ms at 50 MHz.
- PRESSED_LEVEL, 0, raw pin level meaning "pressed" (0 = active-low keys).

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- address  input  2  register select.
- chipselect  input  1  slave select.
- read  input  1  read strobe.
- write  input  1  write strobe.
- writedata  input  32  write data.
- pushbuttons  input  NUM_BUTTONS  raw asynchronous button pins.
- readdata  output  32  registered read data.
- irq  output  1  level interrupt, active-high.

Behaviour:
- Clock/reset: one clock, clk. reset_n is asynchronous and active-low. All flops clear on reset_n low, regardless of clk.
- Reset values: readdata=0, irq=0, mask=0, edgecapture=0, all counters=0. Sync flops and debounced state are set to the released level (~PRESSED_LEVEL), so no false press follows reset.
- Synchroniser: 2-flop per button. s = second-flop output.
- Debounce, per button:
  - State db and counter cnt.
  - If s==db: cnt<=0.
  - Else if cnt==DEBOUNCE_CYCLES-1: db<=s, cnt<=0.
  - Else: cnt<=cnt+1.
  - db changes exactly DEBOUNCE_CYCLES cycles after s first differs. Any glitch back to db restarts the count.
  - Pin-to-db latency = 2 + DEBOUNCE_CYCLES cycles.
- Pressed vector: pressed[i] = (db[i]==PRESSED_LEVEL).
- Press event: pressed[i] 0->1 in a cycle. Release events are ignored.
- Register map (word address):
  - 0 STATE (RO): readdata[NUM_BUTTONS-1:0]=pressed, upper bits 0. Writes ignored.
  - 1 MASK (RW): bits[NUM_BUTTONS-1:0]. Upper writedata bits discarded, read back as 0.
  - 2 EDGECAPTURE (R/W1C): bit i sets on a press event. Writing 1 to bit i clears it; writing 0 has no effect.
  - 3 PRESSCOUNT (RO, write clears): byte i = 8-bit count of press events for button i (buttons 0-3 only). Count wraps 255->0. Any write to address 3 clears all counts.
- Read timing: when chipselect&&read, readdata <= selected register on the next clk edge (1-cycle latency). In any cycle without chipselect&&read, readdata <= 0.
- Write timing: a write takes effect on the clk edge where chipselect&&write is high. Write without chipselect is ignored.
- Simultaneous events:
  - Press event and W1C clear of the same edgecapture bit in the same cycle: set wins, bit stays 1.
  - Press event and PRESSCOUNT clear in the same cycle: result count = 1 for that button, 0 for others.
  - read&&write together: both performed. readdata returns the pre-write value.
- irq: registered, irq <= |(edgecapture & mask). It asserts 1 cycle after the edgecapture bit sets and deasserts 1 cycle after the bit is cleared or masked.
- Reset mid-debounce: the count is discarded. A button held through reset release is seen as released. A press event is then generated 2+DEBOUNCE_CYCLES cycles after reset_n rises.

Test Plan (DEBOUNCE_CYCLES=4, NUM_BUTTONS=4, PRESSED_LEVEL=0):
- Reset: hold reset_n low, pushbuttons=4'b1111 -> readdata=0, irq=0. Reading addresses 0-3 after release returns 0.
- Clean press: drive pushbuttons[2]=0 and hold. Check each stage:
  - STATE reads 32'h4 starting exactly 6 cycles after the pin edge (plus 1-cycle read latency).
  - EDGECAPTURE reads 32'h4.
  - PRESSCOUNT reads 32'h0001_0000.
- Bounce rejection: toggle pushbuttons[0] low for 3 cycles, high for 1, repeated 5 times -> STATE stays 0 and EDGECAPTURE stays 0. A final 6-cycle hold low -> EDGECAPTURE bit0=1.
- Interrupt: write MASK=32'h1, then press button 0 -> irq=1 one cycle after edgecapture sets. Then:
  - Write EDGECAPTURE=32'h1 -> irq=0 the next cycle.
  - Press button 1 with mask 0x1 -> irq stays 0.
- Set/clear collision: align a W1C write of bit 3 with the cycle button 3's press event fires -> EDGECAPTURE bit3 reads 1 afterwards.
- Counter wrap and clear:
  - 256 presses of button 1 -> PRESSCOUNT byte1 = 8'h00.
  - A 257th press -> byte1 = 8'h01.
  - Write address 3 (any data) -> PRESSCOUNT reads 0.
  - A reset_n pulse while button 0 is held low -> no event until 6 cycles after reset release, then EDGECAPTURE bit0=1.

Source files
------------

// File: rtl/pushbutton_event_controller.sv
// Pushbutton controller: 2-flop sync, per-button debounce, press-edge capture,
// press counters and a maskable level interrupt behind a 4-word register slave.
module pushbutton_event_controller #(
    parameter int   NUM_BUTTONS     = 4,
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic PRESSED_LEVEL   = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [1:0]             address,
    input  logic                   chipselect,
    input  logic                   read,
    input  logic                   write,
    input  logic [31:0]            writedata,
    input  logic [NUM_BUTTONS-1:0] pushbuttons,
    output logic [31:0]            readdata,
    output logic                   irq
);

    localparam int CW   = $clog2(DEBOUNCE_CYCLES);
    localparam int NCNT = (NUM_BUTTONS < 4) ? NUM_BUTTONS : 4;
    localparam logic [NUM_BUTTONS-1:0] RELEASED = {NUM_BUTTONS{~PRESSED_LEVEL}};

    logic [NUM_BUTTONS-1:0] sync1_q, sync2_q;
    logic [NUM_BUTTONS-1:0] db_q, db_d;
    logic [CW-1:0]          dbc_q [NUM_BUTTONS];
    logic [CW-1:0]          dbc_d [NUM_BUTTONS];
    logic [NUM_BUTTONS-1:0] ec_q, ec_d;
    logic [NUM_BUTTONS-1:0] mask_q, mask_d;
    logic [7:0]             cnt_q [NCNT];
    logic [7:0]             cnt_d [NCNT];
    logic [31:0]            rd_q, rd_d;
    logic                   irq_q, irq_d;

    logic [NUM_BUTTONS-1:0] pressed_q, pressed_d, press_evt;
    logic                   wr_mask, wr_ec, wr_cnt;
    logic                   unused_wdata;

    assign unused_wdata = ^writedata[31:NUM_BUTTONS];

    assign wr_mask = chipselect && write && (address == 2'd1);
    assign wr_ec   = chipselect && write && (address == 2'd2);
    assign wr_cnt  = chipselect && write && (address == 2'd3);

    // db ^ RELEASED yields 1 exactly where the debounced level equals PRESSED_LEVEL
    assign pressed_q = db_q ^ RELEASED;
    assign pressed_d = db_d ^ RELEASED;
    assign press_evt = pressed_d & ~pressed_q;

    always_comb begin
        db_d = db_q;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            dbc_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (dbc_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    db_d[i] = sync2_q[i];
                end else begin
                    dbc_d[i] = dbc_q[i] + CW'(1);
                end
            end
        end
    end

    // Press event ORed in after the clear so a same-cycle press wins
    always_comb begin
        ec_d   = (ec_q & ~(wr_ec ? writedata[NUM_BUTTONS-1:0] : '0)) | press_evt;
        mask_d = wr_mask ? writedata[NUM_BUTTONS-1:0] : mask_q;
        irq_d  = |(ec_q & mask_q);
        for (int i = 0; i < NCNT; i++) begin
            cnt_d[i] = wr_cnt ? {7'd0, press_evt[i]} : cnt_q[i] + {7'd0, press_evt[i]};
        end
    end

    always_comb begin
        rd_d = '0;
        if (chipselect && read) begin
            case (address)
                2'd0: rd_d[NUM_BUTTONS-1:0] = pressed_q;
                2'd1: rd_d[NUM_BUTTONS-1:0] = mask_q;
                2'd2: rd_d[NUM_BUTTONS-1:0] = ec_q;
                2'd3: begin
                    for (int i = 0; i < NCNT; i++) begin
                        rd_d[8*i +: 8] = cnt_q[i];
                    end
                end
                default: rd_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= RELEASED;
            sync2_q <= RELEASED;
            db_q    <= RELEASED;
            ec_q    <= '0;
            mask_q  <= '0;
            rd_q    <= '0;
            irq_q   <= 1'b0;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                dbc_q[i] <= '0;
            end
            for (int i = 0; i < NCNT; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= pushbuttons;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            ec_q    <= ec_d;
            mask_q  <= mask_d;
            rd_q    <= rd_d;
            irq_q   <= irq_d;
            for (int i = 0; i < NUM_BUTTONS; i++) begin
                dbc_q[i] <= dbc_d[i];
            end
            for (int i = 0; i < NCNT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign readdata = rd_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_pushbutton_event_controller.sv
// Bench for pushbutton_event_controller: directed stimulus, a window-based
// reference model compared every cycle, plus literal spot checks.
module tb_pushbutton_event_controller;
    localparam int NB = 4;
    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect, read, write;
    logic [31:0] writedata;
    logic [NB-1:0] pb;
    logic [31:0] readdata;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    pushbutton_event_controller #(
        .NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(DC), .PRESSED_LEVEL(1'b0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .read(read), .write(write), .writedata(writedata), .pushbuttons(pb),
        .readdata(readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    // Model: a button's debounced level becomes L once the last DC
    // synchronised samples (pin samples delayed two clocks) are all L.
    logic [NB-1:0] m_smp [0:DC];
    logic [NB-1:0] m_db, m_db_n, m_evt, m_ec, m_ec_n, m_mask, m_mask_n;
    logic [DC-1:0] m_win [NB];
    logic [7:0]    m_cnt [4];
    logic [7:0]    m_cnt_n [4];
    logic [31:0]   m_rd, m_rd_n;
    logic          m_irq, m_irq_n;

    always_comb begin
        m_db_n = m_db;
        for (int i = 0; i < NB; i++) begin
            m_win[i] = '0;
            for (int j = 1; j <= DC; j++) m_win[i][j-1] = m_smp[j][i];
            if (&m_win[i]) m_db_n[i] = 1'b1;
            else if (~|m_win[i]) m_db_n[i] = 1'b0;
        end
        m_evt    = m_db & ~m_db_n;
        m_ec_n   = (m_ec & ~((chipselect && write && address == 2'd2) ? writedata[NB-1:0] : 4'h0)) | m_evt;
        m_mask_n = (chipselect && write && address == 2'd1) ? writedata[NB-1:0] : m_mask;
        m_irq_n  = |(m_ec & m_mask);
        for (int i = 0; i < 4; i++) begin
            if (chipselect && write && address == 2'd3) m_cnt_n[i] = m_evt[i] ? 8'd1 : 8'd0;
            else m_cnt_n[i] = m_cnt[i] + (m_evt[i] ? 8'd1 : 8'd0);
        end
        m_rd_n = 32'h0;
        if (chipselect && read) begin
            case (address)
                2'd0: m_rd_n = {28'h0, ~m_db};
                2'd1: m_rd_n = {28'h0, m_mask};
                2'd2: m_rd_n = {28'h0, m_ec};
                default: m_rd_n = {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]};
            endcase
        end
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j <= DC; j++) m_smp[j] <= '1;
            m_db <= '1; m_ec <= '0; m_mask <= '0; m_rd <= '0; m_irq <= 1'b0;
            for (int i = 0; i < 4; i++) m_cnt[i] <= '0;
        end else begin
            m_smp[0] <= pb;
            for (int j = 1; j <= DC; j++) m_smp[j] <= m_smp[j-1];
            m_db <= m_db_n; m_ec <= m_ec_n; m_mask <= m_mask_n;
            m_rd <= m_rd_n; m_irq <= m_irq_n;
            for (int i = 0; i < 4; i++) m_cnt[i] <= m_cnt_n[i];
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #3;
            check("model_readdata", readdata, m_rd);
            check("model_irq", {31'h0, irq}, {31'h0, m_irq});
        end
    end

    // Bus tasks are entered on a negedge and return on the next negedge.
    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        d = readdata;
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0; writedata = '0;
    endtask

    task automatic press(input int b);
        pb[b] = 1'b0;
        repeat (7) @(negedge clk);
        pb[b] = 1'b1;
        repeat (7) @(negedge clk);
    endtask

    logic [31:0] d;

    initial begin
        reset_n = 1'b0; pb = '1; address = '0; chipselect = 1'b0;
        read = 1'b0; write = 1'b0; writedata = '0;
        repeat (3) @(negedge clk);
        check("reset_readdata", readdata, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            check("post_reset_read", d, 32'h0);
        end
        wr(2'd0, 32'hF);
        rd(2'd0, d); check("state_write_ignored", d, 32'h0);

        // Clean press of button 2 with STATE polled every cycle
        pb = 4'b1011; chipselect = 1'b1; read = 1'b1; address = 2'd0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            check("state_latency", readdata, (n >= 7) ? 32'h4 : 32'h0);
        end
        chipselect = 1'b0; read = 1'b0;
        rd(2'd2, d); check("clean_ec", d, 32'h4);
        rd(2'd3, d); check("clean_count", d, 32'h0001_0000);
        pb = '1; repeat (8) @(negedge clk);
        wr(2'd2, 32'h4);

        // Bounce on button 0
        for (int k = 0; k < 5; k++) begin
            pb[0] = 1'b0; repeat (3) @(negedge clk);
            pb[0] = 1'b1; @(negedge clk);
        end
        rd(2'd0, d); check("bounce_state", d, 32'h0);
        rd(2'd2, d); check("bounce_ec", d, 32'h0);
        pb[0] = 1'b0; repeat (8) @(negedge clk);
        rd(2'd2, d); check("bounce_final_ec", d, 32'h1);
        pb[0] = 1'b1; repeat (8) @(negedge clk);
        wr(2'd2, 32'h1);

        // Interrupt
        wr(2'd1, 32'hFFFF_FFF1);
        rd(2'd1, d); check("mask_readback", d, 32'h1);
        pb = 4'b1110;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            check("irq_assert", {31'h0, irq}, (n >= 7) ? 32'h1 : 32'h0);
        end
        wr(2'd2, 32'h1);
        check("irq_hold_after_clear", {31'h0, irq}, 32'h1);
        @(negedge clk);
        check("irq_deassert", {31'h0, irq}, 32'h0);
        pb = '1; repeat (8) @(negedge clk);
        pb = 4'b1101; repeat (10) @(negedge clk);
        check("irq_masked", {31'h0, irq}, 32'h0);
        rd(2'd2, d); check("masked_ec", d, 32'h2);
        pb = '1; repeat (8) @(negedge clk);
        wr(2'd2, 32'h2);

        // W1C clear aligned with the press event of button 3
        pb = 4'b0111; repeat (5) @(negedge clk);
        wr(2'd2, 32'h8);
        rd(2'd2, d); check("set_beats_clear", d, 32'h8);
        pb = '1; repeat (8) @(negedge clk);
        wr(2'd3, 32'h0);
        pb = 4'b0111; repeat (5) @(negedge clk);
        wr(2'd3, 32'hDEAD);
        rd(2'd3, d); check("count_clear_collision", d, 32'h0100_0000);
        pb = '1; repeat (8) @(negedge clk);
        wr(2'd2, 32'h8);

        // Counter wrap and clear
        wr(2'd3, 32'h0);
        for (int k = 0; k < 256; k++) press(1);
        rd(2'd3, d); check("count_wrap", d, 32'h0);
        chipselect = 1'b1; read = 1'b1; write = 1'b1; address = 2'd2; writedata = 32'h2;
        @(negedge clk);
        d = readdata;
        chipselect = 1'b0; read = 1'b0; write = 1'b0; writedata = '0;
        check("rw_prewrite_value", d, 32'h2);
        rd(2'd2, d); check("rw_write_done", d, 32'h0);
        press(1);
        rd(2'd3, d); check("count_257", d, 32'h0000_0100);
        wr(2'd3, 32'h5);
        rd(2'd3, d); check("count_cleared", d, 32'h0);

        // Reset pulse mid-debounce with button 0 held
        pb = 4'b1110; repeat (3) @(negedge clk);
        reset_n = 1'b0; repeat (2) @(negedge clk);
        check("midreset_readdata", readdata, 32'h0);
        reset_n = 1'b1; chipselect = 1'b1; read = 1'b1; address = 2'd2;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            check("post_reset_event", readdata, (n >= 7) ? 32'h1 : 32'h0);
        end
        chipselect = 1'b0; read = 1'b0;
        pb = '1; repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
